// File: rtl/cvita_seqnum_mux_if.sv
// Bundles the N-input CVITA streams and the single output stream of the
// sequence-number mux. The mux itself uses the slave modport; whatever feeds
// the inputs and drains the output uses the master modport.
interface cvita_seqnum_mux_if #(
  parameter int NUM_INPUTS = 2
) ();
  logic [NUM_INPUTS*64-1:0] i_tdata;
  logic [NUM_INPUTS-1:0]    i_tlast;
  logic [NUM_INPUTS-1:0]    i_tvalid;
  logic [NUM_INPUTS-1:0]    i_tready;
  logic [63:0]              o_tdata;
  logic                     o_tlast;
  logic                     o_tvalid;
  logic                     o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/cvita_seqnum_mux.sv
// Whole-packet CVITA mux with one shared sequence-number counter.
// Packets are arbitrated round-robin or fixed-priority; the header beat of
// each forwarded packet optionally gets its seqnum field replaced so the
// output sequence is contiguous no matter how the inputs interleave.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no packet owns the output; pick a winner among valid inputs
//   PASS  | input `grant` is passed straight through until its tlast beat
module cvita_seqnum_mux #(
  parameter int          NUM_INPUTS     = 2,
  parameter int          PRIO           = 0,
  parameter int          REWRITE_SEQNUM = 1,
  parameter logic [11:0] SEQNUM_INIT    = 12'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  cvita_seqnum_mux_if.slave             bus,
  output logic [$clog2(NUM_INPUTS)-1:0] grant,
  output logic                          busy,
  output logic [11:0]                   seqnum,
  output logic [31:0]                   pkt_count
);

  localparam int GW = $clog2(NUM_INPUTS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          first_q, first_d;
  logic [11:0]   seqnum_q, seqnum_d;
  logic [31:0]   pkt_count_q, pkt_count_d;

  logic [GW-1:0] winner;
  int            arb_idx;
  logic [63:0]   sel_tdata;
  logic          sel_tvalid;
  logic          sel_tlast;
  logic          in_pass;
  logic          beat_acc;
  logic          pkt_end;

  assign in_pass  = (state_q == ST_PASS);
  assign beat_acc = in_pass & sel_tvalid & bus.o_tready;
  assign pkt_end  = beat_acc & sel_tlast;

  // Pick the winner; scanning the search order backwards lets the earliest hit win.
  always_comb begin
    winner  = '0;
    arb_idx = 0;
    for (int off = NUM_INPUTS; off >= 1; off--) begin
      if (PRIO != 0) arb_idx = off - 1;
      else           arb_idx = (int'(last_grant_q) + off) % NUM_INPUTS;
      if (bus.i_tvalid[arb_idx]) winner = GW'(arb_idx);
    end
  end

  // Select the granted input's beat.
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant_q == GW'(k)) begin
        sel_tdata  = bus.i_tdata[64*k +: 64];
        sel_tvalid = bus.i_tvalid[k];
        sel_tlast  = bus.i_tlast[k];
      end
    end
  end

  // Zero-latency pass-through in PASS, with the header seqnum swapped on the first beat.
  always_comb begin
    bus.o_tdata  = '0;
    bus.o_tlast  = 1'b0;
    bus.o_tvalid = 1'b0;
    bus.i_tready = '0;
    if (in_pass) begin
      bus.o_tvalid = sel_tvalid;
      bus.o_tlast  = sel_tlast;
      if (first_q && (REWRITE_SEQNUM != 0))
        bus.o_tdata = {sel_tdata[63:60], seqnum_q, sel_tdata[47:0]};
      else
        bus.o_tdata = sel_tdata;
      for (int k = 0; k < NUM_INPUTS; k++)
        bus.i_tready[k] = (grant_q == GW'(k)) & bus.o_tready;
    end
  end

  // Next-state: arbitrate in IDLE, track first beat and packet end in PASS.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    seqnum_d     = seqnum_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_tvalid) begin
          grant_d = winner;
          first_d = 1'b1;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (beat_acc) first_d = 1'b0;
        if (pkt_end) begin
          seqnum_d     = seqnum_q + 12'd1;
          pkt_count_d  = pkt_count_q + 32'd1;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; clear behaves exactly like reset and overrides a coincident tlast.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_INPUTS - 1);
      first_q      <= 1'b0;
      seqnum_q     <= SEQNUM_INIT;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      seqnum_q     <= seqnum_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = in_pass;
  assign seqnum    = seqnum_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: doc/cvita_seqnum_mux.md
# cvita_seqnum_mux

Parametrised N-input CVITA packet multiplexer for the RFNoC block-port source path. It arbitrates whole packets from `NUM_INPUTS` CVITA streams onto one output, either round-robin or with fixed priority. When enabled, it rewrites the 12-bit sequence number in every outgoing header from one internal counter, so the sequence stays consistent however the inputs interleave. It generalises the two-input AXI-Wrapper/CVITA mux plus sequence-number fix-up used in the test-bench export block, and adds selectable arbitration, wrap control and status outputs.

## Interface
- `NUM_INPUTS`, 2: number of input CVITA streams, 2..16.
- `PRIO`, 0: arbitration mode.
  - 0: round-robin.
  - 1: fixed priority; the lowest index wins.
- `REWRITE_SEQNUM`, 1:
  - 1: replace header bits [59:48] with the internal counter.
  - 0: pass headers unmodified.
- `SEQNUM_INIT`, 0: 12-bit counter value after reset or clear.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous, active-high soft reset; same effect as `reset`.
- `i_tdata` in NUM_INPUTS*64: input data; input k occupies bits [64k+63:64k].
- `i_tlast` in NUM_INPUTS: per-input end of packet.
- `i_tvalid` in NUM_INPUTS: per-input valid.
- `i_tready` out NUM_INPUTS: per-input ready.
- `o_tdata` out 64: output data.
- `o_tlast` out 1: output end of packet.
- `o_tvalid` out 1: output valid.
- `o_tready` in 1: downstream ready.
- `grant` out $clog2(NUM_INPUTS): index of the input currently owning the output.
- `busy` out 1: high while a packet is in flight (PASS state).
- `seqnum` out 12: sequence number the next packet will carry.
- `pkt_count` out 32: packets forwarded since reset or clear; wraps.

## Operation
- CVITA header beat layout:
  - [63:62] packet type
  - [61] has_time
  - [60] eob
  - [59:48] seqnum
  - [47:32] length
  - [31:0] SID
- FSM with two states, IDLE and PASS.
- IDLE:
  - `i_tready`=0 and `o_tvalid`=0.
  - If any `i_tvalid` is high, register the winner into `grant` and go to PASS.
  - Round-robin: search from (last_grant+1) mod NUM_INPUTS upward and wrap. last_grant resets to NUM_INPUTS-1, so input 0 wins first.
  - Fixed priority: the lowest set index wins.
- PASS:
  - The output is a combinational pass-through of input `grant`.
  - `o_tvalid`=`i_tvalid[grant]`, `o_tlast`=`i_tlast[grant]`, `i_tready[grant]`=`o_tready`.
  - All other `i_tready` bits are 0.
- First-beat flag:
  - Set on entry to PASS.
  - Cleared on the first accepted beat (`o_tvalid & o_tready`).
- Header rewrite: while first-beat is set and REWRITE_SEQNUM=1, `o_tdata` = {i_tdata[63:60], seqnum, i_tdata[47:0]}. All other beats pass unmodified.
- End of packet, on an accepted beat with `o_tlast`:
  - `seqnum` increments modulo 4096 (4095 wraps to 0) regardless of REWRITE_SEQNUM.
  - `pkt_count` increments modulo 2^32.
  - last_grant is set to `grant`.
  - The FSM returns to IDLE.
- A single-beat packet (tlast on the header beat) is legal. It is rewritten, counted, and the FSM returns to IDLE.
- No payload inspection: the length field and has_time are never checked or altered.

## Timing
- Reset/clear values:
  - FSM=IDLE, `grant`=0, `busy`=0.
  - `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0.
  - `i_tready`=0.
  - `seqnum`=SEQNUM_INIT, `pkt_count`=0.
- Arbitration latency: 1 cycle. `i_tvalid` first high in cycle n gives `o_tvalid` high in cycle n+1.
- Data path in PASS has 0-cycle latency. tvalid/tready follow AXI-Stream rules, and the output holds while `o_tready`=0.
- Packet spacing: at least one idle cycle (IDLE) between packets, including back-to-back packets on the same input.
- `grant` changes only in IDLE. It is stable for the whole packet.
- Simultaneous events:
  - `clear` or `reset` together with an accepted tlast: reset/clear wins, and `seqnum` = SEQNUM_INIT with no increment.
  - `clear` mid-packet: the packet is truncated with no tlast emitted. Downstream recovery is the system's responsibility.
- `i_tvalid` dropping in IDLE before the grant: the registered grant still goes to PASS, and the FSM waits there for valid.

## Test plan
- **Reset values:** hold `reset` for 3 cycles with all inputs valid -> all outputs match the reset values; `o_tvalid` first rises on the 2nd cycle after reset deasserts.
- **Seqnum rewrite:** NUM_INPUTS=2, PRIO=0, REWRITE_SEQNUM=1. Input 0 sends 3-beat packets with header seqnum 0xABC; input 1 sends the same. Both stay continuously valid -> output grants alternate 0,1,0,1; headers carry seqnum 0,1,2,3 with bits [63:60] and [47:0] unchanged; `pkt_count`=4.
- **Fixed priority:** PRIO=1, NUM_INPUTS=4, inputs 1 and 3 valid -> input 1 is served until it goes idle, then input 3; input 3 is never granted while input 1 is valid at arbitration time.
- **Wrap:** SEQNUM_INIT=4094, three 1-beat packets -> headers carry 4094, 4095, 0; then `seqnum`=1.
- **Backpressure:** `o_tready` toggled randomly during an 8-beat packet -> exactly 8 beats are accepted in order; `o_tdata` is held stable while stalled; the header is rewritten exactly once.
- **Clear vs. end of packet:** `clear` asserted mid-packet at beat 3 -> next cycle FSM=IDLE, `seqnum`=SEQNUM_INIT, `pkt_count`=0. `clear` coincident with an accepted tlast -> `seqnum`=SEQNUM_INIT, not incremented.
